// File: rtl/z8_mc_if.sv
// Memory-side bundle of the z8 multicycle core: instruction fetch and data access
// handshakes. The core drives the master side, memories the slave side.
interface z8_mc_if #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int INSTR_W = 24 + DATA_W
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_rdata;

   logic               dmem_req;
   logic               dmem_we;
   logic [ADDR_W-1:0]  dmem_addr;
   logic [DATA_W-1:0]  dmem_wdata;
   logic               dmem_ready;
   logic [DATA_W-1:0]  dmem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/z8_mc_core.sv
// Multicycle z8 core: FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK control with a small
// register file, ALU and {N,Z,C} flags; memories sit behind req/ready handshakes.
module z8_mc_core #(
   parameter int               DATA_W   = 16,
   parameter int               ADDR_W   = 16,
   parameter int               NUM_REGS = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   localparam int              INSTR_W  = 24 + DATA_W,
   localparam int              RIDX_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_en,
   z8_mc_if.master           bus,
   output logic [ADDR_W-1:0] pc,
   output logic [2:0]        flags,
   output logic              retire,
   output logic              halted,
   output logic              illegal
);

   // Opcode map (top byte of the instruction word); anything else traps.
   localparam logic [7:0] OP_LDR = 8'h01;
   localparam logic [7:0] OP_LDD = 8'h02;
   localparam logic [7:0] OP_LDM = 8'h03;
   localparam logic [7:0] OP_STR = 8'h04;
   localparam logic [7:0] OP_STD = 8'h05;
   localparam logic [7:0] OP_ADD = 8'h10;
   localparam logic [7:0] OP_ADR = 8'h11;
   localparam logic [7:0] OP_SBD = 8'h12;
   localparam logic [7:0] OP_SBR = 8'h13;
   localparam logic [7:0] OP_AND = 8'h14;
   localparam logic [7:0] OP_ANR = 8'h15;
   localparam logic [7:0] OP_ORD = 8'h16;
   localparam logic [7:0] OP_ORR = 8'h17;
   localparam logic [7:0] OP_XOD = 8'h18;
   localparam logic [7:0] OP_XOR = 8'h19;
   localparam logic [7:0] OP_CPD = 8'h1A;
   localparam logic [7:0] OP_CPR = 8'h1B;
   localparam logic [7:0] OP_JMP = 8'h20;
   localparam logic [7:0] OP_JZ  = 8'h21;
   localparam logic [7:0] OP_JNZ = 8'h22;
   localparam logic [7:0] OP_JC  = 8'h23;
   localparam logic [7:0] OP_HLT = 8'h3F;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_HALT
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR
   } alu_op_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [2:0]          flags_q, flags_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic [2:0]          res_flags_q, res_flags_d;
   logic [DATA_W-1:0]   mdr_q, mdr_d;
   logic                taken_q, taken_d;
   logic                illegal_q, illegal_d;
   logic                started_q, started_d;
   logic                fetch_pend_q, fetch_pend_d;

   logic [7:0]          opc;
   logic [RIDX_W-1:0]   rd_idx;
   logic [RIDX_W-1:0]   rs_idx;
   logic [DATA_W-1:0]   imm;
   logic                ir_unused;

   logic                legal, is_hlt, is_alu, is_cmp, uses_imm;
   logic                is_load, is_store, is_mem, writes_rd, cond_true;
   alu_op_e             alu_op;

   logic [DATA_W:0]     sum_w, diff_w;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c;
   logic [DATA_W-1:0]   wb_val;
   logic                fetch_go;

   assign opc       = ir_q[INSTR_W-1 -: 8];
   assign rd_idx    = ir_q[INSTR_W-16 +: RIDX_W];
   assign rs_idx    = ir_q[DATA_W +: RIDX_W];
   assign imm       = ir_q[DATA_W-1:0];
   assign ir_unused = ^ir_q;

   // Once a fetch request is raised it stays up until accepted, even if run_en drops.
   assign fetch_go  = started_q && (run_en || fetch_pend_q);

   always_comb begin
      legal     = 1'b1;
      is_hlt    = 1'b0;
      is_alu    = 1'b0;
      is_cmp    = 1'b0;
      uses_imm  = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      writes_rd = 1'b0;
      alu_op    = ALU_ADD;
      cond_true = 1'b0;
      unique case (opc)
         OP_LDR: writes_rd = 1'b1;
         OP_LDD: begin writes_rd = 1'b1; uses_imm = 1'b1; end
         OP_LDM: begin writes_rd = 1'b1; is_load = 1'b1; end
         OP_STR, OP_STD: is_store = 1'b1;
         OP_ADD: begin is_alu = 1'b1; uses_imm = 1'b1; alu_op = ALU_ADD; end
         OP_ADR: begin is_alu = 1'b1; alu_op = ALU_ADD; end
         OP_SBD: begin is_alu = 1'b1; uses_imm = 1'b1; alu_op = ALU_SUB; end
         OP_SBR: begin is_alu = 1'b1; alu_op = ALU_SUB; end
         OP_AND: begin is_alu = 1'b1; uses_imm = 1'b1; alu_op = ALU_AND; end
         OP_ANR: begin is_alu = 1'b1; alu_op = ALU_AND; end
         OP_ORD: begin is_alu = 1'b1; uses_imm = 1'b1; alu_op = ALU_OR; end
         OP_ORR: begin is_alu = 1'b1; alu_op = ALU_OR; end
         OP_XOD: begin is_alu = 1'b1; uses_imm = 1'b1; alu_op = ALU_XOR; end
         OP_XOR: begin is_alu = 1'b1; alu_op = ALU_XOR; end
         OP_CPD: begin is_cmp = 1'b1; uses_imm = 1'b1; alu_op = ALU_SUB; end
         OP_CPR: begin is_cmp = 1'b1; alu_op = ALU_SUB; end
         OP_JMP: cond_true = 1'b1;
         OP_JZ:  cond_true = flags_q[1];
         OP_JNZ: cond_true = !flags_q[1];
         OP_JC:  cond_true = flags_q[0];
         OP_HLT: is_hlt = 1'b1;
         default: legal = 1'b0;
      endcase
      if (is_alu) writes_rd = 1'b1;
   end

   assign is_mem = is_load || is_store;

   // Carry flag is the extra top bit: carry-out for add, borrow for subtract.
   always_comb begin
      sum_w   = {1'b0, a_q} + {1'b0, b_q};
      diff_w  = {1'b0, a_q} - {1'b0, b_q};
      alu_res = '0;
      alu_c   = 1'b0;
      unique case (alu_op)
         ALU_ADD: {alu_c, alu_res} = sum_w;
         ALU_SUB: {alu_c, alu_res} = diff_w;
         ALU_AND: alu_res = a_q & b_q;
         ALU_OR:  alu_res = a_q | b_q;
         ALU_XOR: alu_res = a_q ^ b_q;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      wb_val = res_q;
      if (is_load) begin
         wb_val = mdr_q;
      end else if (opc == OP_LDR || opc == OP_LDD) begin
         wb_val = b_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:     if (fetch_go && bus.imem_ready) state_d = S_DECODE;
         S_DECODE:    state_d = (!legal || is_hlt) ? S_HALT : S_EXECUTE;
         S_EXECUTE:   state_d = is_mem ? S_MEMORY : S_WRITEBACK;
         S_MEMORY:    if (bus.dmem_ready) state_d = S_WRITEBACK;
         S_WRITEBACK: state_d = S_FETCH;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_FETCH;
      endcase
   end

   always_comb begin
      bus.imem_req   = (state_q == S_FETCH) && fetch_go;
      bus.imem_addr  = pc_q;
      bus.dmem_req   = (state_q == S_MEMORY);
      bus.dmem_we    = (state_q == S_MEMORY) && is_store;
      bus.dmem_addr  = imm[ADDR_W-1:0];
      bus.dmem_wdata = (opc == OP_STD) ? a_q : b_q;
      retire         = (state_q == S_WRITEBACK);
      halted         = (state_q == S_HALT);
      illegal        = illegal_q;
      pc             = pc_q;
      flags          = flags_q;
   end

   // Datapath next-state: each stage only touches the registers it owns.
   always_comb begin
      pc_d         = pc_q;
      ir_d         = ir_q;
      regs_d       = regs_q;
      flags_d      = flags_q;
      a_d          = a_q;
      b_d          = b_q;
      res_d        = res_q;
      res_flags_d  = res_flags_q;
      mdr_d        = mdr_q;
      taken_d      = taken_q;
      illegal_d    = illegal_q;
      started_d    = 1'b1;
      fetch_pend_d = (state_q == S_FETCH) && fetch_go && !bus.imem_ready;
      unique case (state_q)
         S_FETCH: begin
            if (fetch_go && bus.imem_ready) ir_d = bus.imem_rdata;
         end
         S_DECODE: begin
            a_d       = regs_q[rd_idx];
            b_d       = uses_imm ? imm : regs_q[rs_idx];
            taken_d   = cond_true;
            illegal_d = !legal;
         end
         S_EXECUTE: begin
            res_d       = alu_res;
            res_flags_d = {alu_res[DATA_W-1], (alu_res == '0), alu_c};
         end
         S_MEMORY: begin
            if (bus.dmem_ready && is_load) mdr_d = bus.dmem_rdata;
         end
         S_WRITEBACK: begin
            if (writes_rd) regs_d[rd_idx] = wb_val;
            if (is_alu || is_cmp) flags_d = res_flags_q;
            pc_d = taken_q ? imm[ADDR_W-1:0] : pc_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         ir_q         <= '0;
         regs_q       <= '{default: '0};
         flags_q      <= '0;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         res_flags_q  <= '0;
         mdr_q        <= '0;
         taken_q      <= 1'b0;
         illegal_q    <= 1'b0;
         started_q    <= 1'b0;
         fetch_pend_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         regs_q       <= regs_d;
         flags_q      <= flags_d;
         a_q          <= a_d;
         b_q          <= b_d;
         res_q        <= res_d;
         res_flags_q  <= res_flags_d;
         mdr_q        <= mdr_d;
         taken_q      <= taken_d;
         illegal_q    <= illegal_d;
         started_q    <= started_d;
         fetch_pend_q <= fetch_pend_d;
      end
   end

endmodule

// File: tb/tb_z8_mc_core.sv
// Bench for z8_mc_core: wait-stated memory responder plus scoreboards of expected
// stores and per-instruction retire latency, filled as each program is written.
module tb_z8_mc_core;

   localparam logic [7:0] OP_LDR = 8'h01;
   localparam logic [7:0] OP_LDD = 8'h02;
   localparam logic [7:0] OP_LDM = 8'h03;
   localparam logic [7:0] OP_STR = 8'h04;
   localparam logic [7:0] OP_STD = 8'h05;
   localparam logic [7:0] OP_ADD = 8'h10;
   localparam logic [7:0] OP_ADR = 8'h11;
   localparam logic [7:0] OP_SBD = 8'h12;
   localparam logic [7:0] OP_SBR = 8'h13;
   localparam logic [7:0] OP_ANR = 8'h15;
   localparam logic [7:0] OP_ORR = 8'h17;
   localparam logic [7:0] OP_XOD = 8'h18;
   localparam logic [7:0] OP_CPD = 8'h1A;
   localparam logic [7:0] OP_JZ  = 8'h21;
   localparam logic [7:0] OP_JNZ = 8'h22;
   localparam logic [7:0] OP_HLT = 8'h3F;
   localparam logic [7:0] OP_BAD = 8'hFF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run_en = 1'b1;
   logic [15:0] pc;
   logic [2:0]  flags;
   logic        retire, halted, illegal;

   z8_mc_if #(.ADDR_W(16), .DATA_W(16), .INSTR_W(40)) bus ();

   z8_mc_core #(
      .DATA_W(16), .ADDR_W(16), .NUM_REGS(4), .RESET_PC(16'h0000)
   ) dut (
      .clk(clk), .reset(reset), .run_en(run_en), .bus(bus),
      .pc(pc), .flags(flags), .retire(retire), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   logic [39:0] imem [0:65535];
   logic [15:0] dmem [0:255];
   logic [31:0] exp_store_q [$];
   int          exp_lat_q [$];
   int          imem_wait = 0;
   int          dmem_wait = 0;
   int          cyc = 0;
   int          fetch_start = 0;
   int          halt_req_cnt = 0;
   int          tests_run = 0;
   int          tests_failed = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Memory responder and scoreboard monitor, both working at the falling edge.
   initial begin
      int          i_cnt = 0;
      int          d_cnt = 0;
      logic [15:0] i_addr = '0;
      logic [15:0] d_addr = '0;
      logic        d_we = 1'b0;
      logic [15:0] d_wdata = '0;
      logic [31:0] st;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      bus.dmem_ready = 1'b0;
      bus.dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (halted === 1'b1 && bus.imem_req === 1'b1) halt_req_cnt++;
         if (retire === 1'b1) begin
            if (exp_lat_q.size() == 0) checkOutput("retire_unexpected", 1, 0);
            else checkOutput("retire_latency", cyc - fetch_start, exp_lat_q.pop_front());
         end
         if (bus.imem_req !== 1'b1) begin
            bus.imem_ready = 1'b0;
            i_cnt = 0;
         end else begin
            if (i_cnt == 0) begin
               i_addr = bus.imem_addr;
               fetch_start = cyc;
            end else begin
               checkOutput("imem_addr_hold", bus.imem_addr, i_addr);
            end
            bus.imem_ready = (i_cnt >= imem_wait);
            bus.imem_rdata = imem[i_addr];
            i_cnt++;
         end
         if (bus.dmem_req !== 1'b1) begin
            bus.dmem_ready = 1'b0;
            d_cnt = 0;
         end else begin
            if (d_cnt == 0) begin
               d_addr  = bus.dmem_addr;
               d_we    = bus.dmem_we;
               d_wdata = bus.dmem_wdata;
            end else begin
               checkOutput("dmem_hold", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, {d_we, d_addr, d_wdata});
            end
            bus.dmem_ready = (d_cnt >= dmem_wait);
            bus.dmem_rdata = dmem[d_addr[7:0]];
            if (bus.dmem_ready && d_we) begin
               dmem[d_addr[7:0]] = d_wdata;
               if (exp_store_q.size() == 0) begin
                  checkOutput("store_unexpected", 1, 0);
               end else begin
                  st = exp_store_q.pop_front();
                  checkOutput("store_addr", d_addr, st[31:16]);
                  checkOutput("store_data", d_wdata, st[15:0]);
               end
            end
            d_cnt++;
         end
      end
   end

   task automatic begin_prog(input int iw, input int dw);
      imem_wait = iw;
      dmem_wait = dw;
      for (int i = 0; i < 65536; i++) imem[i] = {OP_BAD, 32'h0};
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      exp_store_q.delete();
      exp_lat_q.delete();
   endtask

   task automatic place(input logic [15:0] addr, input logic [7:0] op, input int rd, input int rs,
                        input logic [15:0] imm);
      imem[addr] = {op, 8'(rd), 8'(rs), imm};
   endtask

   // Instruction on the executed path: also queue its expected retire latency.
   task automatic emit(input logic [15:0] addr, input logic [7:0] op, input int rd, input int rs,
                       input logic [15:0] imm);
      place(addr, op, rd, rs, imm);
      if (op != OP_HLT && op != OP_BAD)
         exp_lat_q.push_back(3 + imem_wait +
                             ((op == OP_LDM || op == OP_STR || op == OP_STD) ? 1 + dmem_wait : 0));
   endtask

   task automatic expect_store(input logic [15:0] addr, input logic [15:0] data);
      exp_store_q.push_back({addr, data});
   endtask

   task automatic run_to_halt(input logic [15:0] exp_pc, input logic [2:0] exp_flags,
                              input logic exp_illegal);
      bit done = 0;
      halt_req_cnt = 0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         #1;
         if (halted === 1'b1) done = 1;
      end
      checkOutput("halted", halted, 1'b1);
      repeat (5) @(negedge clk);
      #1;
      checkOutput("halt_pc", pc, exp_pc);
      checkOutput("halt_flags", flags, exp_flags);
      checkOutput("illegal", illegal, exp_illegal);
      checkOutput("halt_no_imem_req", halt_req_cnt, 0);
      checkOutput("sb_store_left", exp_store_q.size(), 0);
      checkOutput("sb_retire_left", exp_lat_q.size(), 0);
   endtask

   task automatic applyStimulus(input logic [15:0] exp_pc, input logic [2:0] exp_flags,
                                input logic exp_illegal);
      reset = 1'b1;
      run_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_to_halt(exp_pc, exp_flags, exp_illegal);
   endtask

   initial begin
      bit hit = 0;

      // Reset in the middle of a wait-stated fetch, then check registers read back as 0.
      begin_prog(2, 0);
      emit(0, OP_LDD, 1, 0, 16'h1234);
      emit(1, OP_LDD, 2, 0, 16'h2222);
      emit(2, OP_LDD, 3, 0, 16'h3333);
      emit(3, OP_HLT, 0, 0, 16'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         #1;
         if (pc == 16'h0002 && bus.imem_ready === 1'b1) hit = 1;
      end
      checkOutput("reach_mid_fetch", hit, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("rst_imem_req", bus.imem_req, 1'b0);
      checkOutput("rst_dmem_req", bus.dmem_req, 1'b0);
      checkOutput("rst_pc", pc, 16'h0000);
      checkOutput("rst_flags", flags, 3'b000);
      checkOutput("rst_status", {retire, halted, illegal}, 3'b000);
      begin_prog(0, 0);
      emit(0, OP_STR, 0, 1, 16'h0010);
      emit(1, OP_STR, 0, 2, 16'h0011);
      emit(2, OP_HLT, 0, 0, 16'h0);
      expect_store(16'h0010, 16'h0000);
      expect_store(16'h0011, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      run_to_halt(16'h0002, 3'b000, 1'b0);

      // Add wrapping to zero: Z and C set, N clear.
      begin_prog(0, 0);
      emit(0, OP_LDD, 1, 0, 16'hFFFF);
      emit(1, OP_ADD, 1, 0, 16'h0001);
      emit(2, OP_STR, 0, 1, 16'h0030);
      emit(3, OP_HLT, 0, 0, 16'h0);
      expect_store(16'h0030, 16'h0000);
      applyStimulus(16'h0003, 3'b011, 1'b0);

      // Three fetch wait cycles per instruction.
      begin_prog(3, 0);
      emit(0, OP_LDD, 0, 0, 16'h0055);
      emit(1, OP_STR, 0, 0, 16'h0070);
      emit(2, OP_HLT, 0, 0, 16'h0);
      expect_store(16'h0070, 16'h0055);
      applyStimulus(16'h0002, 3'b000, 1'b0);

      // Store then load back with two data wait cycles.
      begin_prog(0, 2);
      emit(0, OP_LDD, 3, 0, 16'hBEEF);
      emit(1, OP_STD, 3, 0, 16'h0020);
      emit(2, OP_LDM, 2, 0, 16'h0020);
      emit(3, OP_STR, 0, 2, 16'h0021);
      emit(4, OP_HLT, 0, 0, 16'h0);
      expect_store(16'h0020, 16'hBEEF);
      expect_store(16'h0021, 16'hBEEF);
      applyStimulus(16'h0004, 3'b000, 1'b0);

      // Compare-and-branch, taken (r0=0) and not taken (r0=5).
      for (int k = 0; k < 2; k++) begin
         begin_prog(0, 0);
         emit(0, OP_LDD, 1, 0, 16'hAAAA);
         emit(1, OP_LDD, 2, 0, 16'h5555);
         emit(2, OP_LDD, 0, 0, (k == 0) ? 16'h0000 : 16'h0005);
         emit(3, OP_CPD, 0, 0, 16'h0000);
         emit(4, OP_JZ, 0, 0, 16'h0100);
         if (k == 0) begin
            place(5, OP_STR, 0, 2, 16'h0040);
            place(6, OP_HLT, 0, 0, 16'h0);
            emit(16'h0100, OP_STR, 0, 1, 16'h0040);
            emit(16'h0101, OP_HLT, 0, 0, 16'h0);
            expect_store(16'h0040, 16'hAAAA);
            applyStimulus(16'h0101, 3'b010, 1'b0);
         end else begin
            emit(5, OP_STR, 0, 2, 16'h0040);
            emit(6, OP_HLT, 0, 0, 16'h0);
            place(16'h0100, OP_STR, 0, 1, 16'h0040);
            place(16'h0101, OP_HLT, 0, 0, 16'h0);
            expect_store(16'h0040, 16'h5555);
            applyStimulus(16'h0006, 3'b000, 1'b0);
         end
      end

      // PC wraps from 0xFFFF to 0x0000 after an LDR.
      begin_prog(0, 0);
      emit(16'h0000, OP_JNZ, 0, 0, 16'hFFFD);
      emit(16'hFFFD, OP_CPD, 0, 0, 16'h0000);
      emit(16'hFFFE, OP_LDD, 2, 0, 16'h7777);
      emit(16'hFFFF, OP_LDR, 1, 2, 16'h0000);
      emit(16'h0000, OP_JNZ, 0, 0, 16'hFFFD);
      emit(16'h0001, OP_STR, 0, 1, 16'h0050);
      emit(16'h0002, OP_HLT, 0, 0, 16'h0);
      expect_store(16'h0050, 16'h7777);
      applyStimulus(16'h0002, 3'b010, 1'b0);

      // Logic ops, rd==rs add and subtract with borrow.
      begin_prog(0, 0);
      emit(0, OP_LDD, 0, 0, 16'h00F0);
      emit(1, OP_LDD, 1, 0, 16'h0F0F);
      emit(2, OP_LDR, 2, 0, 16'h0000);
      emit(3, OP_ORR, 2, 1, 16'h0000);
      emit(4, OP_STR, 0, 2, 16'h0060);
      emit(5, OP_LDR, 3, 0, 16'h0000);
      emit(6, OP_ANR, 3, 1, 16'h0000);
      emit(7, OP_STR, 0, 3, 16'h0061);
      emit(8, OP_XOD, 1, 0, 16'hFFFF);
      emit(9, OP_ADR, 1, 1, 16'h0000);
      emit(10, OP_STR, 0, 1, 16'h0062);
      emit(11, OP_SBD, 2, 0, 16'h0FFF);
      emit(12, OP_STR, 0, 2, 16'h0064);
      emit(13, OP_SBR, 0, 1, 16'h0000);
      emit(14, OP_STR, 0, 0, 16'h0063);
      emit(15, OP_HLT, 0, 0, 16'h0);
      expect_store(16'h0060, 16'h0FFF);
      expect_store(16'h0061, 16'h0000);
      expect_store(16'h0062, 16'hE1E0);
      expect_store(16'h0064, 16'h0000);
      expect_store(16'h0063, 16'h1F10);
      applyStimulus(16'h000F, 3'b001, 1'b0);

      // Undefined opcode traps into HALT with illegal set.
      begin_prog(0, 0);
      emit(0, OP_LDD, 0, 0, 16'h0001);
      emit(1, OP_BAD, 0, 0, 16'h0000);
      applyStimulus(16'h0001, 3'b000, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
